// File: rtl/warp_scalar_reg_file.sv
// Multi-warp scalar register file: one bank per warp, three registered read ports with
// write-to-read bypass, a protected execution-mask register and a pending-write scoreboard.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTRUCTION_MEMORY_ADDRESS_WIDTH
`define INSTRUCTION_MEMORY_ADDRESS_WIDTH 16
`endif

package warp_scalar_reg_file_pkg;
  typedef enum logic [2:0] {
    ALU_OUT          = 3'd0,
    LSU_OUT          = 3'd1,
    IMMEDIATE        = 3'd2,
    PC_PLUS_1        = 3'd3,
    VECTOR_TO_SCALAR = 3'd4
  } reg_input_mux_t;
endpackage

module warp_scalar_reg_file
  import warp_scalar_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32,
  parameter int PC_WIDTH   = `INSTRUCTION_MEMORY_ADDRESS_WIDTH,
  localparam int WARP_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_req,
  input  logic [WARP_W-1:0]               rd_warp,
  input  logic [ADDR_W-1:0]               rs1_addr,
  input  logic [ADDR_W-1:0]               rs2_addr,
  input  logic [ADDR_W-1:0]               rs3_addr,
  input  logic [ADDR_W-1:0]               rd_dest_addr,
  output logic                            hazard,
  output logic [DATA_WIDTH-1:0]           rs1,
  output logic [DATA_WIDTH-1:0]           rs2,
  output logic [DATA_WIDTH-1:0]           rs3,
  output logic                            rs_valid,
  input  logic                            issue_valid,
  input  logic [WARP_W-1:0]               issue_warp,
  input  logic [ADDR_W-1:0]               issue_rd,
  input  logic                            wb_valid,
  input  logic [WARP_W-1:0]               wb_warp,
  input  logic [ADDR_W-1:0]               wb_rd,
  input  reg_input_mux_t                  wb_src,
  input  logic [DATA_WIDTH-1:0]           alu_out,
  input  logic [DATA_WIDTH-1:0]           lsu_out,
  input  logic [DATA_WIDTH-1:0]           immediate,
  input  logic [DATA_WIDTH-1:0]           vector_to_scalar_data,
  input  logic [PC_WIDTH-1:0]             pc,
  output logic [NUM_WARPS*DATA_WIDTH-1:0] warp_execution_mask,
  output logic                            wb_blocked
);

  localparam logic [ADDR_W-1:0] MASK_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] bank [NUM_WARPS][NUM_REGS];
  logic [NUM_REGS-1:0]   pending [NUM_WARPS];

  logic [PC_WIDTH-1:0]   pc_inc;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  src_legal;
  logic                  wb_blocked_now;
  logic                  wb_write;
  logic [3:0]            pend_hit;

  assign pc_inc = pc + PC_WIDTH'(1);

  always_comb begin
    wb_data   = '0;
    src_legal = 1'b1;
    case (wb_src)
      ALU_OUT:          wb_data = alu_out;
      LSU_OUT:          wb_data = lsu_out;
      IMMEDIATE:        wb_data = immediate;
      PC_PLUS_1:        wb_data = DATA_WIDTH'(pc_inc);
      VECTOR_TO_SCALAR: wb_data = vector_to_scalar_data;
      default:          src_legal = 1'b0;
    endcase
  end

  // The mask register only accepts vector-to-scalar writes; anything else is rejected.
  assign wb_blocked_now = wb_valid && (wb_rd == MASK_IDX) && (wb_src != VECTOR_TO_SCALAR);
  assign wb_write       = wb_valid && src_legal && (wb_rd != '0) && !wb_blocked_now;

  // Read ports: index 0 is hard zero, then forward a same-cycle accepted write.
  for (genvar gi = 0; gi < 3; gi++) begin : g_read
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] val;
    assign addr = (gi == 0) ? rs1_addr : (gi == 1) ? rs2_addr : rs3_addr;
    always_comb begin
      if (addr == '0)
        val = '0;
      else if (wb_write && (wb_warp == rd_warp) && (wb_rd == addr))
        val = wb_data;
      else
        val = bank[rd_warp][addr];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_hazard
    logic [ADDR_W-1:0] addr;
    assign addr = (gi == 0) ? rs1_addr : (gi == 1) ? rs2_addr :
                  (gi == 2) ? rs3_addr : rd_dest_addr;
    assign pend_hit[gi] = (addr != '0) && pending[rd_warp][addr];
  end

  assign hazard = rd_req && (|pend_hit);

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_mask
    assign warp_execution_mask[gi*DATA_WIDTH +: DATA_WIDTH] = bank[gi][NUM_REGS-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++)
          bank[w][r] <= (r == NUM_REGS - 1) ? {DATA_WIDTH{1'b1}} : '0;
        pending[w] <= '0;
      end
      rs1        <= '0;
      rs2        <= '0;
      rs3        <= '0;
      rs_valid   <= 1'b0;
      wb_blocked <= 1'b0;
    end else begin
      if (wb_write)
        bank[wb_warp][wb_rd] <= wb_data;
      // Set is applied after clear so a newer issued writer stays pending.
      if (wb_valid)
        pending[wb_warp][wb_rd] <= 1'b0;
      if (issue_valid && (issue_rd != '0))
        pending[issue_warp][issue_rd] <= 1'b1;
      rs_valid <= rd_req;
      if (rd_req) begin
        rs1 <= g_read[0].val;
        rs2 <= g_read[1].val;
        rs3 <= g_read[2].val;
      end
      wb_blocked <= wb_blocked_now;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wb_valid)
      assert (src_legal) else $error("warp_scalar_reg_file: illegal wb_src %0d", wb_src);
  end

endmodule
